// File: rtl/hash_pipe_if.sv
// Valid/ready key-in and hash-out bundle for hash_pipe, plus status outputs.
interface hash_pipe_if #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_key;
  logic [W-1:0]     in_mask;
  logic [TAG_W-1:0] in_tag;
  logic             in_bypass;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_hash;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [31:0]      out_count;

  modport master (
    output in_valid, in_key, in_mask, in_tag, in_bypass, out_ready,
    input  in_ready, out_valid, out_hash, out_tag, busy, out_count
  );

  modport slave (
    input  in_valid, in_key, in_mask, in_tag, in_bypass, out_ready,
    output in_ready, out_valid, out_hash, out_tag, busy, out_count
  );
endinterface

// File: rtl/hash_pipe.sv
// hash_pipe: 7-stage masked integer-hash pipeline with valid/ready flow control.
// Back-pressure ripples combinationally from out_ready so empty stages always fill.
module hash_pipe #(
  parameter int unsigned W     = 64,
  parameter int unsigned TAG_W = 32
) (
  input logic        clk,
  input logic        rst,
  hash_pipe_if.slave bus
);
  localparam int NStg = 7;

  logic [NStg-1:0]  r_vld;
  logic [W-1:0]     r_key  [NStg];
  logic [W-1:0]     r_mask [NStg];
  logic [TAG_W-1:0] r_tag  [NStg];
  logic             r_byp  [NStg];
  logic [31:0]      r_count;

  logic [NStg-1:0]  w_adv;
  logic             w_in_ready;
  logic             w_accept;
  logic [NStg-1:0]  w_vld_src;
  logic [W-1:0]     w_src_key  [NStg];
  logic [W-1:0]     w_src_mask [NStg];
  logic [TAG_W-1:0] w_src_tag  [NStg];
  logic             w_src_byp  [NStg];
  logic [W-1:0]     w_nxt_key  [NStg];

  function automatic logic [W-1:0] stage_fn(input int unsigned idx, input logic [W-1:0] k,
                                            input logic [W-1:0] m);
    logic [W-1:0] res;
    case (idx)
      0:       res = (~k + (k << 21)) & m;
      1:       res = k ^ (k >> 24);
      2:       res = (k + (k << 3) + (k << 8)) & m;
      3:       res = k ^ (k >> 14);
      4:       res = (k + (k << 2) + (k << 4)) & m;
      5:       res = k ^ (k >> 28);
      6:       res = (k + (k << 31)) & m;
      default: res = k;
    endcase
    return res;
  endfunction

  // Stage i moves unless it and every stage after it are full while the sink stalls.
  always_comb begin
    logic tail_full;
    tail_full = 1'b1;
    w_adv     = '0;
    for (int i = NStg - 1; i >= 0; i--) begin
      tail_full = tail_full & r_vld[i];
      w_adv[i]  = bus.out_ready | ~tail_full;
    end
  end

  assign w_in_ready = w_adv[0] & ~rst;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_vld_src  = {r_vld[NStg-2:0], w_accept};

  for (genvar g = 0; g < NStg; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_src_key[g]  = bus.in_key;
      assign w_src_mask[g] = bus.in_mask;
      assign w_src_tag[g]  = bus.in_tag;
      assign w_src_byp[g]  = bus.in_bypass;
    end else begin : g_body
      assign w_src_key[g]  = r_key[g-1];
      assign w_src_mask[g] = r_mask[g-1];
      assign w_src_tag[g]  = r_tag[g-1];
      assign w_src_byp[g]  = r_byp[g-1];
    end
    // Bypass entries are masked once on entry and then carried untouched.
    assign w_nxt_key[g] = w_src_byp[g] ?
                          ((g == 0) ? (w_src_key[g] & w_src_mask[g]) : w_src_key[g]) :
                          stage_fn(g, w_src_key[g], w_src_mask[g]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < NStg; i++) begin
        if (w_adv[i]) r_vld[i] <= w_vld_src[i];
      end
      if (r_vld[NStg-1] && bus.out_ready) r_count <= r_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NStg; i++) begin
      if (w_adv[i]) begin
        r_key[i]  <= w_nxt_key[i];
        r_mask[i] <= w_src_mask[i];
        r_tag[i]  <= w_src_tag[i];
        r_byp[i]  <= w_src_byp[i];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld[NStg-1];
  assign bus.out_hash  = r_key[NStg-1];
  assign bus.out_tag   = r_tag[NStg-1];
  assign bus.busy      = |r_vld;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_hash_pipe.sv
// Directed self-checking bench for hash_pipe (64-bit and 32-bit builds).
module tb_hash_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hash_pipe_if #(.W(64), .TAG_W(32)) bus64 ();
  hash_pipe_if #(.W(32), .TAG_W(8))  bus32 ();

  hash_pipe #(.W(64), .TAG_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));
  hash_pipe #(.W(32), .TAG_W(8))  u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int n_vec = 0;
  int n_bad = 0;
  int exp_count = 0;

  localparam logic [63:0] DKEY [7] = '{64'h0, 64'h1, 64'h1234, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,
                                       64'h2, 64'hA5A5_0000_FFFF_1234};
  localparam logic [63:0] DMASK [7] = '{64'h3, 64'h1, 64'hFF, 64'h0, 64'hF, 64'hFF,
                                        64'hFFFF_FFFF_FFFF_FFFF};
  localparam bit DBYP [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] DTAG [7] = '{32'h11, 32'h22, 32'h5, 32'h33, 32'h44, 32'h55, 32'h66};
  localparam logic [63:0] DEXP [7] = '{64'h3, 64'h0, 64'h34, 64'h0, 64'h3, 64'hC9,
                                       64'hA5A5_0000_FFFF_1234};

  // Straight transcription of the stage equations, truncated to w bits after every step.
  function automatic logic [63:0] model(input logic [63:0] k0, input logic [63:0] m0,
                                        input bit byp, input int w);
    logic [63:0] mw, k, m;
    mw = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    k  = k0 & mw;
    m  = m0 & mw;
    if (byp) return k & m;
    k = ((~k) + (k << 21)) & m & mw;
    k = (k ^ (k >> 24)) & mw;
    k = (k + (k << 3) + (k << 8)) & m & mw;
    k = (k ^ (k >> 14)) & mw;
    k = (k + (k << 2) + (k << 4)) & m & mw;
    k = (k ^ (k >> 28)) & mw;
    k = (k + (k << 31)) & m & mw;
    return k;
  endfunction

  function automatic logic [63:0] vec_key(input int i);
    return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [63:0] vec_mask(input int i);
    return (i % 3 == 2) ? 64'hFFFF_FFFF_0000_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic drive64(input int i);
    bus64.in_key    = vec_key(i);
    bus64.in_mask   = vec_mask(i);
    bus64.in_bypass = (i % 5 == 4);
    bus64.in_tag    = 32'(i);
  endtask

  task automatic test_reset();
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; drive64(0);
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.in_key = '0; bus32.in_mask = '0; bus32.in_tag = '0; bus32.in_bypass = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus64.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_out_valid: got %b want 0", bus64.out_valid); end
    n_vec++; if (bus64.busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy: got %b want 0", bus64.busy); end
    n_vec++; if (bus64.out_count !== 32'd0) begin n_bad++;
      $display("FAIL reset_out_count: got %0d want 0", bus64.out_count); end
    n_vec++; if (bus64.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", bus64.in_ready); end
    n_vec++; if (bus32.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_w32_out_valid: got %b want 0", bus32.out_valid); end
    exp_count = 0;
  endtask

  task automatic test_directed();
    int lat;
    for (int t = 0; t < 7; t++) begin
      @(negedge clk); #1;
      n_vec++; if (bus64.in_ready !== 1'b1) begin n_bad++;
        $display("FAIL dir_in_ready[%0d]: got %b want 1", t, bus64.in_ready); end
      bus64.in_valid = 1'b1; bus64.out_ready = 1'b1;
      bus64.in_key = DKEY[t]; bus64.in_mask = DMASK[t];
      bus64.in_bypass = DBYP[t]; bus64.in_tag = DTAG[t];
      @(negedge clk); #1;
      bus64.in_valid = 1'b0;
      lat = 1;
      while (bus64.out_valid !== 1'b1 && lat < 20) begin
        @(negedge clk); #1;
        lat++;
      end
      n_vec++; if (lat != 7) begin n_bad++;
        $display("FAIL dir_latency[%0d]: got %0d want 7", t, lat); end
      n_vec++; if (bus64.out_hash !== DEXP[t]) begin n_bad++;
        $display("FAIL dir_hash[%0d]: got %h want %h", t, bus64.out_hash, DEXP[t]); end
      n_vec++; if (bus64.out_tag !== DTAG[t]) begin n_bad++;
        $display("FAIL dir_tag[%0d]: got %h want %h", t, bus64.out_tag, DTAG[t]); end
      exp_count++;
    end
  endtask

  // Feeds n vectors while out_ready follows rpat; checks order, data, hold and count.
  task automatic run_stream(input int n, input logic [15:0] rpat, input bit chk_thru,
                            input int base);
    logic [63:0] eh [$];
    logic [31:0] et [$];
    logic [63:0] hh, h;
    logic [31:0] ht, tg;
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    bit hold = 1'b0;
    while (got < n && cyc < n * 8 + 40) begin
      @(negedge clk);
      bus64.out_ready = rpat[cyc % 16];
      if (sent < n) begin bus64.in_valid = 1'b1; drive64(base + sent); end
      else bus64.in_valid = 1'b0;
      #1;
      if (hold) begin
        n_vec++;
        if (bus64.out_valid !== 1'b1 || bus64.out_hash !== hh || bus64.out_tag !== ht) begin
          n_bad++;
          $display("FAIL stream_hold[%0d]: got v=%b %h/%h want v=1 %h/%h", cyc,
                   bus64.out_valid, bus64.out_hash, bus64.out_tag, hh, ht);
        end
      end
      hold = 1'b0;
      if (bus64.out_valid === 1'b1) begin
        if (bus64.out_ready) begin
          n_vec++;
          if (eh.size() == 0) begin n_bad++;
            $display("FAIL stream_spurious[%0d]: got %h want no result", cyc, bus64.out_hash);
          end else begin
            h = eh.pop_front(); tg = et.pop_front();
            if (bus64.out_hash !== h || bus64.out_tag !== tg) begin n_bad++;
              $display("FAIL stream_data[%0d]: got %h/%h want %h/%h", got,
                       bus64.out_hash, bus64.out_tag, h, tg);
            end
          end
          got++; exp_count++;
          if (first < 0) first = cyc;
          last = cyc;
        end else begin
          hold = 1'b1; hh = bus64.out_hash; ht = bus64.out_tag;
        end
      end
      if (chk_thru && sent < n) begin
        n_vec++; if (bus64.in_ready !== 1'b1) begin n_bad++;
          $display("FAIL thru_in_ready[%0d]: got %b want 1", cyc, bus64.in_ready); end
      end
      if (bus64.in_valid && bus64.in_ready) begin
        eh.push_back(model(vec_key(base + sent), vec_mask(base + sent),
                           ((base + sent) % 5 == 4), 64));
        et.push_back(32'(base + sent));
        sent++;
      end
      cyc++;
    end
    bus64.in_valid = 1'b0;
    n_vec++; if (got != n) begin n_bad++;
      $display("FAIL stream_count: got %0d want %0d", got, n); end
    if (chk_thru) begin
      n_vec++; if (first != 7) begin n_bad++;
        $display("FAIL thru_first: got cycle %0d want 7", first); end
      n_vec++; if (last - first != n - 1) begin n_bad++;
        $display("FAIL thru_span: got %0d want %0d", last - first, n - 1); end
    end
    @(negedge clk);
    bus64.out_ready = 1'b1;
    #1;
    n_vec++; if (bus64.out_count !== 32'(exp_count)) begin n_bad++;
      $display("FAIL stream_out_count: got %0d want %0d", bus64.out_count, exp_count); end
  endtask

  task automatic test_back_to_back();
    run_stream(12, 16'hFFFF, 1'b1, 100);
  endtask

  task automatic test_ready_toggle();
    run_stream(40, 16'b1011_0010_1110_0101, 1'b0, 200);
    run_stream(20, 16'h00F1, 1'b0, 250);
  endtask

  task automatic test_fill_stall();
    logic [63:0] eh [$];
    logic [63:0] hh, h;
    int acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus64.out_ready = 1'b0; bus64.in_valid = 1'b1; drive64(300 + acc);
      #1;
      if (bus64.in_ready) begin
        eh.push_back(model(vec_key(300 + acc), vec_mask(300 + acc), ((300 + acc) % 5 == 4), 64));
        acc++;
      end
    end
    @(negedge clk); #1;
    n_vec++; if (acc != 7) begin n_bad++;
      $display("FAIL stall_accepts: got %0d want 7", acc); end
    n_vec++; if (bus64.in_ready !== 1'b0) begin n_bad++;
      $display("FAIL stall_in_ready: got %b want 0", bus64.in_ready); end
    n_vec++; if (bus64.busy !== 1'b1) begin n_bad++;
      $display("FAIL stall_busy: got %b want 1", bus64.busy); end
    n_vec++; if (bus64.out_valid !== 1'b1) begin n_bad++;
      $display("FAIL stall_out_valid: got %b want 1", bus64.out_valid); end
    hh = bus64.out_hash;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (bus64.out_hash !== hh || bus64.out_valid !== 1'b1) begin n_bad++;
      $display("FAIL stall_hold: got %h want %h", bus64.out_hash, hh); end
    bus64.in_valid = 1'b0; bus64.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      h = (eh.size() != 0) ? eh.pop_front() : 64'h0;
      n_vec++; if (bus64.out_valid !== 1'b1 || bus64.out_hash !== h) begin n_bad++;
        $display("FAIL drain[%0d]: got v=%b %h want v=1 %h", i, bus64.out_valid,
                 bus64.out_hash, h); end
      exp_count++;
      @(negedge clk); #1;
    end
    n_vec++; if (bus64.out_valid !== 1'b0 || bus64.busy !== 1'b0) begin n_bad++;
      $display("FAIL drain_empty: got v=%b busy=%b want 0/0", bus64.out_valid, bus64.busy); end
    n_vec++; if (bus64.out_count !== 32'(exp_count)) begin n_bad++;
      $display("FAIL drain_out_count: got %0d want %0d", bus64.out_count, exp_count); end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus64.out_ready = 1'b1; bus64.in_valid = 1'b1; drive64(400 + i);
    end
    @(negedge clk);
    rst = 1'b1; bus64.in_valid = 1'b1; drive64(404);
    @(negedge clk);
    rst = 1'b0; bus64.in_valid = 1'b0;
    #1;
    exp_count = 0;
    n_vec++; if (bus64.out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_out_valid: got %b want 0", bus64.out_valid); end
    n_vec++; if (bus64.busy !== 1'b0) begin n_bad++;
      $display("FAIL flush_busy: got %b want 0", bus64.busy); end
    n_vec++; if (bus64.out_count !== 32'd0) begin n_bad++;
      $display("FAIL flush_out_count: got %0d want 0", bus64.out_count); end
    n_vec++; if (bus64.in_ready !== 1'b1) begin n_bad++;
      $display("FAIL flush_in_ready: got %b want 1", bus64.in_ready); end
    repeat (12) begin
      @(negedge clk); #1;
      if (bus64.out_valid === 1'b1) seen++;
    end
    n_vec++; if (seen != 0) begin n_bad++;
      $display("FAIL flush_ghosts: got %0d results want 0", seen); end
  endtask

  task automatic test_w32();
    logic [31:0] eh [$];
    logic [31:0] h;
    logic [63:0] k;
    int sent = 0, got = 0, cyc = 0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      bus32.out_ready = 1'b1;
      k = vec_key(500 + sent);
      if (sent < 8) begin
        bus32.in_valid = 1'b1; bus32.in_key = k[31:0];
        bus32.in_mask = 32'hFFFF_FFFF; bus32.in_bypass = 1'b0; bus32.in_tag = 8'(sent);
      end else bus32.in_valid = 1'b0;
      #1;
      if (bus32.out_valid === 1'b1) begin
        h = (eh.size() != 0) ? eh.pop_front() : 32'h0;
        n_vec++; if (bus32.out_hash !== h || bus32.out_tag !== 8'(got)) begin n_bad++;
          $display("FAIL w32_data[%0d]: got %h/%h want %h/%h", got, bus32.out_hash,
                   bus32.out_tag, h, 8'(got)); end
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        k = model({32'h0, k[31:0]}, 64'hFFFF_FFFF, 1'b0, 32);
        eh.push_back(k[31:0]);
        sent++;
      end
      cyc++;
    end
    bus32.in_valid = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (got != 8) begin n_bad++;
      $display("FAIL w32_count: got %0d want 8", got); end
    n_vec++; if (bus32.out_count !== 32'd8) begin n_bad++;
      $display("FAIL w32_out_count: got %0d want 8", bus32.out_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ready_toggle();
    test_fill_stall();
    test_reset_flush();
    test_w32();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
